// File: rtl/my_ram_8_arbiter.sv
// Round-robin arbiter for two requesters sharing an 8 x 16 RAM port.
// After every reset the RAM is swept to zero before any grant is issued.

module my_ram_8 (
  input  logic        clk,
  input  logic        load,
  input  logic [2:0]  addr,
  input  logic [15:0] din,
  output logic [15:0] dout
);

  logic [15:0] mem_r [0:7];

  // Synchronous write port; the read port below is combinational.
  always_ff @(posedge clk) begin
    if (load) begin
      mem_r[addr] <= din;
    end
  end

  assign dout = mem_r[addr];

endmodule

module my_ram_8_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic        we_a,
  input  logic [2:0]  addr_a,
  input  logic [15:0] wdata_a,
  output logic        gnt_a,
  output logic        rvalid_a,
  output logic [15:0] rdata_a,
  input  logic        req_b,
  input  logic        we_b,
  input  logic [2:0]  addr_b,
  input  logic [15:0] wdata_b,
  output logic        gnt_b,
  output logic        rvalid_b,
  output logic [15:0] rdata_b,
  output logic        busy
);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;
  localparam logic       PTR_A    = 1'b0;
  localparam logic       PTR_B    = 1'b1;

  logic [0:0]  state_r;
  logic [2:0]  cnt_r;
  logic        ptr_r;
  logic        rvalid_a_r;
  logic        rvalid_b_r;
  logic [15:0] rdata_a_r;
  logic [15:0] rdata_b_r;

  logic        serve_s;
  logic        gnt_a_s;
  logic        gnt_b_s;
  logic        ram_load_s;
  logic [2:0]  ram_addr_s;
  logic [15:0] ram_din_s;
  logic [15:0] ram_dout_s;

  // Grant decision: a lone requester wins, contention goes to the pointer side.
  always_comb begin
    serve_s = (state_r == ST_SERVE) && !reset;
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    if (serve_s) begin
      if (req_a && (!req_b || (ptr_r == PTR_A))) begin
        gnt_a_s = 1'b1;
      end else if (req_b) begin
        gnt_b_s = 1'b1;
      end else begin
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
      end
    end else begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
    end
  end

  // RAM port mux: sweep writes zeros, otherwise the granted requester drives.
  always_comb begin
    ram_load_s = 1'b0;
    ram_addr_s = 3'd0;
    ram_din_s  = 16'h0000;
    if (state_r == ST_INIT) begin
      ram_load_s = !reset;
      ram_addr_s = cnt_r;
      ram_din_s  = 16'h0000;
    end else if (gnt_a_s) begin
      ram_load_s = we_a;
      ram_addr_s = addr_a;
      ram_din_s  = wdata_a;
    end else if (gnt_b_s) begin
      ram_load_s = we_b;
      ram_addr_s = addr_b;
      ram_din_s  = wdata_b;
    end else begin
      ram_load_s = 1'b0;
      ram_addr_s = 3'd0;
      ram_din_s  = 16'h0000;
    end
  end

  my_ram_8 u_ram (
    .clk  (clk),
    .load (ram_load_s),
    .addr (ram_addr_s),
    .din  (ram_din_s),
    .dout (ram_dout_s)
  );

  // Sweep/serve sequencing, priority pointer and registered read returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_INIT;
      cnt_r      <= 3'd0;
      ptr_r      <= PTR_A;
      rvalid_a_r <= 1'b0;
      rvalid_b_r <= 1'b0;
      rdata_a_r  <= 16'h0000;
      rdata_b_r  <= 16'h0000;
    end else begin
      case (state_r)
        ST_INIT: begin
          cnt_r <= cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            state_r <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          // The side just served yields priority to the other one.
          if (gnt_a_s) begin
            ptr_r <= PTR_B;
          end else if (gnt_b_s) begin
            ptr_r <= PTR_A;
          end
        end
        default: begin
          state_r <= ST_INIT;
        end
      endcase
      rvalid_a_r <= gnt_a_s && !we_a;
      rvalid_b_r <= gnt_b_s && !we_b;
      if (gnt_a_s && !we_a) begin
        rdata_a_r <= ram_dout_s;
      end
      if (gnt_b_s && !we_b) begin
        rdata_b_r <= ram_dout_s;
      end
    end
  end

  assign gnt_a    = gnt_a_s;
  assign gnt_b    = gnt_b_s;
  assign rvalid_a = rvalid_a_r;
  assign rvalid_b = rvalid_b_r;
  assign rdata_a  = rdata_a_r;
  assign rdata_b  = rdata_b_r;
  assign busy     = (state_r == ST_INIT);

endmodule

// File: tb/tb_my_ram_8_arbiter.sv
// Bench for my_ram_8_arbiter: directed table, reset corner sequences and
// randomized traffic checked against a countdown/array reference model.

module tb_my_ram_8_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [2:0]  addr_a = 3'd0, addr_b = 3'd0;
  logic [15:0] wdata_a = 16'h0, wdata_b = 16'h0;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b, busy;
  logic [15:0] rdata_a, rdata_b;

  always #5 clk = ~clk;

  my_ram_8_arbiter dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: words still to clear, memory image, pointer, read returns.
  logic [15:0] mem_m [8];
  int          init_left;
  logic        ptr_b_m;
  logic        rvalid_a_m, rvalid_b_m;
  logic [15:0] rdata_a_m, rdata_b_m;
  logic        got_ga, got_gb, got_busy;

  typedef struct {
    logic ra; logic wa; logic [2:0] aa; logic [15:0] da;
    logic rb; logic wb; logic [2:0] ab; logic [15:0] db;
    logic ega; logic egb;
    logic eva; logic [15:0] eda; logic evb; logic [15:0] edb;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    init_left  = 8;
    ptr_b_m    = 1'b0;
    rvalid_a_m = 1'b0;
    rvalid_b_m = 1'b0;
    rdata_a_m  = 16'h0;
    rdata_b_m  = 16'h0;
  endtask

  // One cycle: drive at negedge, check grants before the edge, outputs after.
  task automatic step(input logic r, input logic ra, input logic wa, input logic [2:0] aa,
                      input logic [15:0] da, input logic rb, input logic wb,
                      input logic [2:0] ab, input logic [15:0] db);
    int win;
    reset = r; req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
    if (r) model_reset();
    #1;
    if (r || init_left > 0) win = 0;
    else if (ra && rb) win = ptr_b_m ? 2 : 1;
    else if (ra) win = 1;
    else if (rb) win = 2;
    else win = 0;
    got_ga = gnt_a; got_gb = gnt_b; got_busy = busy;
    chk("gnt_a", gnt_a, win == 1);
    chk("gnt_b", gnt_b, win == 2);
    chk("busy_pre", busy, init_left > 0);
    @(posedge clk);
    if (!r) begin
      rvalid_a_m = 1'b0;
      rvalid_b_m = 1'b0;
      if (init_left > 0) begin
        mem_m[8 - init_left] = 16'h0;
        init_left--;
      end else if (win == 1) begin
        if (wa) mem_m[aa] = da;
        else begin rdata_a_m = mem_m[aa]; rvalid_a_m = 1'b1; end
        ptr_b_m = 1'b1;
      end else if (win == 2) begin
        if (wb) mem_m[ab] = db;
        else begin rdata_b_m = mem_m[ab]; rvalid_b_m = 1'b1; end
        ptr_b_m = 1'b0;
      end
    end
    @(negedge clk);
    chk("rvalid_a", rvalid_a, rvalid_a_m);
    chk("rdata_a", rdata_a, rdata_a_m);
    chk("rvalid_b", rvalid_b, rvalid_b_m);
    chk("rdata_b", rdata_b, rdata_b_m);
    chk("busy_post", busy, init_left > 0);
  endtask

  task automatic idle(input logic r);
    step(r, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
  endtask

  // Release reset and sweep while A tries to write 0xFFFF to word 3.
  task automatic sweep_and_count(input string tag);
    int nb;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1, 3'd3, 16'hFFFF, 1'b1, 1'b0, 3'd3, 16'h0);
      chk({tag, "_gnt_during_busy"}, {got_ga, got_gb}, 2'b00);
      if (got_busy) nb++;
    end
    chk({tag, "_busy_len"}, nb, 8);
    chk({tag, "_busy_fall"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) mem_m[i] = 16'hxxxx;
    model_reset();
    @(negedge clk);
    step(1'b1, 1'b1, 1'b1, 3'd3, 16'hFFFF, 1'b1, 1'b0, 3'd0, 16'h0);
    chk("rst_outputs", {busy, gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b},
        {1'b1, 4'b0000, 32'h0});
    sweep_and_count("sweep1");

    // Directed table, starting with the priority pointer at A.
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, 1'b0, 3'(i), 16'h0, 1'b0, 1'b0, 3'd0, 16'h0,
                      1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000});
    tbl.push_back('{1'b1, 1'b1, 3'd5, 16'h1234, 1'b0, 1'b0, 3'd0, 16'h0,
                    1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000});
    tbl.push_back('{1'b1, 1'b0, 3'd5, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0,
                    1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h0000});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0,
                    1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h0000});
    tbl.push_back('{1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd5, 16'h0,
                    1'b0, 1'b1, 1'b0, 16'h1234, 1'b1, 16'h1234});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'(i), 16'h0,
                      1'b0, 1'b1, 1'b0, 16'h1234, 1'b1, 16'h0000});
    for (int i = 0; i < 2; i++) begin
      tbl.push_back('{1'b1, 1'b1, 3'd1, 16'hAAAA, 1'b1, 1'b0, 3'd2, 16'h0,
                      1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h0000});
      tbl.push_back('{1'b1, 1'b1, 3'd1, 16'hAAAA, 1'b1, 1'b0, 3'd2, 16'h0,
                      1'b0, 1'b1, 1'b0, 16'h1234, 1'b1, 16'h0000});
    end
    tbl.push_back('{1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd1, 16'h0,
                    1'b0, 1'b1, 1'b0, 16'h1234, 1'b1, 16'hAAAA});
    tbl.push_back('{1'b1, 1'b0, 3'd1, 16'h0, 1'b1, 1'b0, 3'd1, 16'h0,
                    1'b1, 1'b0, 1'b1, 16'hAAAA, 1'b0, 16'hAAAA});
    foreach (tbl[i]) begin
      step(1'b0, tbl[i].ra, tbl[i].wa, tbl[i].aa, tbl[i].da,
           tbl[i].rb, tbl[i].wb, tbl[i].ab, tbl[i].db);
      chk($sformatf("row%0d_gnt", i), {got_ga, got_gb}, {tbl[i].ega, tbl[i].egb});
      chk($sformatf("row%0d_a", i), {rvalid_a, rdata_a}, {tbl[i].eva, tbl[i].eda});
      chk($sformatf("row%0d_b", i), {rvalid_b, rdata_b}, {tbl[i].evb, tbl[i].edb});
    end

    // Reset asserted in sweep cycle 4, then a full rerun of the sweep.
    idle(1'b1);
    for (int i = 0; i < 3; i++) idle(1'b0);
    idle(1'b1);
    chk("midsweep_busy", busy, 1'b1);
    sweep_and_count("sweep2");

    // Reset asserted during a granted read: transfer dropped, no rvalid pulse.
    reset = 1'b0; req_a = 1'b1; we_a = 1'b0; addr_a = 3'd1; req_b = 1'b0;
    #1;
    chk("midread_gnt", gnt_a, 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("midread_rst_gnt", {gnt_a, gnt_b, busy}, 3'b001);
    @(posedge clk);
    @(negedge clk);
    chk("midread_no_rvalid", {rvalid_a, rdata_a}, 17'h0);
    sweep_and_count("sweep3");

    // Completed read, then reset while rvalid is high.
    step(1'b0, 1'b1, 1'b0, 3'd1, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("rd_before_rst", rvalid_a, 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_clears_rvalid", {rvalid_a, rdata_a, busy}, {17'h0, 1'b1});
    idle(1'b1);
    for (int i = 0; i < 8; i++) idle(1'b0);

    // Contention right after reset: A first, then strict alternation.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b1, 3'd1, 16'h5A5A, 1'b1, 1'b0, 3'd2, 16'h0);
      chk($sformatf("alt%0d", i), {got_ga, got_gb}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           3'($urandom_range(0, 7)), 16'($urandom), ($urandom_range(0, 3) != 0),
           1'($urandom), 3'($urandom_range(0, 7)), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
